// File: rtl/uart_tx_arbiter_if.sv
// Bus between the UART transmit arbiter and the rest of the design.
// Requester side: i_req/i_data in, o_grant/o_done/o_err/o_busy/o_owner out.
// UART side: o_Tx_DV/o_Tx_b/o_enable/o_select out, i_ready/i_data_recieved/
// i_data_sent in.
// The master modport is the arbiter. The slave modport is the requesters plus
// the UART.
interface uart_tx_arbiter_if #(
  parameter int N = 4,
  parameter int m = 8
);
  localparam int OW = $clog2(N);

  logic [N-1:0]   i_req;
  logic [N*m-1:0] i_data;
  logic [N-1:0]   o_grant;
  logic [N-1:0]   o_done;
  logic           o_err;
  logic           o_busy;
  logic [OW-1:0]  o_owner;

  logic           o_Tx_DV;
  logic [m-1:0]   o_Tx_b;
  logic           o_enable;
  logic           o_select;
  logic           i_ready;
  logic           i_data_recieved;
  logic           i_data_sent;

  modport master (
    input  i_req, i_data, i_ready, i_data_recieved, i_data_sent,
    output o_grant, o_done, o_err, o_busy, o_owner,
           o_Tx_DV, o_Tx_b, o_enable, o_select
  );

  modport slave (
    output i_req, i_data, i_ready, i_data_recieved, i_data_sent,
    input  o_grant, o_done, o_err, o_busy, o_owner,
           o_Tx_DV, o_Tx_b, o_enable, o_select
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter between N byte requesters.
// It picks a winner, loads that winner's byte and raises DV. It holds
// enable/select for the whole frame. It pulses o_grant[k] when the UART acks
// the byte and o_done[k] when the frame has been sent. If no ack arrives
// within ACK_TIMEOUT cycles, it aborts and pulses o_err.
// Ports: i_clk, i_rst (sync, active-high), bus (uart_tx_arbiter_if.master).
module uart_tx_arbiter #(
  parameter int N           = 4,
  parameter int m           = 8,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic                i_clk,
  input  logic                i_rst,
  uart_tx_arbiter_if.master   bus
);
  localparam int OW = $clog2(N);
  localparam int CW = $clog2(ACK_TIMEOUT);

  typedef enum logic [1:0] {IDLE, SEND, WAIT_DONE} st_t;

  st_t           st, st_n;
  logic [OW-1:0] last, last_n, owner, owner_n, win;
  logic [CW-1:0] cnt, cnt_n;
  logic [m-1:0]  txb, txb_n;
  logic          dv, dv_n, en, en_n, busy, busy_n, err, err_n, win_vld;
  logic [N-1:0]  grant, grant_n, done, done_n, own_oh;

  // Search from last+1 upward with wrap. Scanning from the far end down lets
  // the nearest requester overwrite the others, so the first hit wins.
  always_comb begin
    win     = '0;
    win_vld = 1'b0;
    for (int i = N; i >= 1; i--) begin
      if (bus.i_req[(int'(last) + i) % N]) begin
        win     = OW'((int'(last) + i) % N);
        win_vld = 1'b1;
      end
    end
  end

  assign own_oh = N'(1) << owner;

  always_comb begin
    st_n    = st;
    last_n  = last;
    cnt_n   = cnt;
    owner_n = owner;
    txb_n   = txb;
    dv_n    = dv;
    en_n    = en;
    busy_n  = busy;
    grant_n = '0;
    done_n  = '0;
    err_n   = 1'b0;
    case (st)
      IDLE: begin
        if (bus.i_ready && win_vld) begin
          txb_n   = bus.i_data[int'(win)*m +: m];
          owner_n = win;
          dv_n    = 1'b1;
          en_n    = 1'b1;
          busy_n  = 1'b1;
          cnt_n   = '0;
          st_n    = SEND;
        end
      end
      SEND: begin
        // An ack takes priority over a timeout in the same cycle.
        if (bus.i_data_recieved) begin
          dv_n    = 1'b0;
          grant_n = own_oh;
          last_n  = owner;
          st_n    = WAIT_DONE;
        end else if (cnt == CW'(ACK_TIMEOUT - 1)) begin
          // The failed requester still counts as served, so it loses its turn.
          dv_n   = 1'b0;
          en_n   = 1'b0;
          busy_n = 1'b0;
          err_n  = 1'b1;
          last_n = owner;
          st_n   = IDLE;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      WAIT_DONE: begin
        if (bus.i_data_sent) begin
          done_n = own_oh;
          en_n   = 1'b0;
          busy_n = 1'b0;
          st_n   = IDLE;
        end
      end
      default: st_n = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      st    <= IDLE;
      last  <= OW'(N - 1);
      cnt   <= '0;
      owner <= '0;
      txb   <= '0;
      dv    <= 1'b0;
      en    <= 1'b0;
      busy  <= 1'b0;
      grant <= '0;
      done  <= '0;
      err   <= 1'b0;
    end else begin
      st    <= st_n;
      last  <= last_n;
      cnt   <= cnt_n;
      owner <= owner_n;
      txb   <= txb_n;
      dv    <= dv_n;
      en    <= en_n;
      busy  <= busy_n;
      grant <= grant_n;
      done  <= done_n;
      err   <= err_n;
    end
  end

  // enable and select come from one flop, so they can never disagree.
  assign bus.o_enable = en;
  assign bus.o_select = en;
  assign bus.o_Tx_DV  = dv;
  assign bus.o_Tx_b   = txb;
  assign bus.o_owner  = owner;
  assign bus.o_busy   = busy;
  assign bus.o_grant  = grant;
  assign bus.o_done   = done;
  assign bus.o_err    = err;
endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter that shares one `UART` transmitter between `N` byte requesters. It selects a requester and loads that requester's byte into the UART. It holds the UART's `i_enable`/`i_select` for the whole frame, then reports acceptance and completion back to the winner. It sits between the requester-side logic (command/status producers) and the single `UART` instance, driving that instance's `i_Tx_DV`, `i_Tx_b`, `i_enable` and `i_select`.

## Interface
- `N`, 4: number of requesters, 2..8
- `m`, 8: byte width; must equal the UART's `m`
- `ACK_TIMEOUT`, 16: maximum cycles in SEND before the attempt is aborted; minimum 2
- `i_clk`  in  1  clock; all logic on the rising edge
- `i_rst`  in  1  reset; synchronous and active-high
- `i_req`  in  N  per-requester level request; held high until that requester's `o_grant` pulse
- `i_data`  in  N*m  packed bytes; requester k uses `[k*m +: m]`, which must be stable while `i_req[k]` is high
- `o_grant`  out  N  one-hot, 1-cycle pulse when the UART has accepted requester k's byte
- `o_done`  out  N  one-hot, 1-cycle pulse when requester k's frame has finished
- `o_err`  out  1  1-cycle pulse on an ack-timeout abort
- `o_busy`  out  1  high from the load cycle until the frame completes or aborts
- `o_owner`  out  $clog2(N)  index of the current or last winner
- `o_Tx_DV`  out  1  to UART `i_Tx_DV`
- `o_Tx_b`  out  m  to UART `i_Tx_b`
- `o_enable`, `o_select`  out  1 each  to UART `i_enable`/`i_select`; always equal
- `i_ready`  in  1  from UART `o_ready`
- `i_data_recieved`  in  1  from UART `o_data_recieved`
- `i_data_sent`  in  1  from UART `o_data_sent`

## Operation
**States**
- IDLE, SEND, WAIT_DONE; all state and outputs are registered.

**Round-robin pointer**
- `last` holds the most recent winner; reset value N-1, so requester 0 has priority first.
- Winner = first k with `i_req[k]` high, searching (last+1) mod N upward with wrap.

**IDLE**
- Arbitrates only when `i_ready`=1 and `|i_req`=1; otherwise stays in IDLE.
- On arbitration, at the clock edge:
  - `o_Tx_b` <= winner's byte, `o_owner` <= winner
  - `o_Tx_DV` <= 1, `o_enable`/`o_select` <= 1, `o_busy` <= 1
  - timeout counter <= 0; next state SEND

**SEND**
- On `i_data_recieved`=1: `o_Tx_DV` <= 0, `o_grant[owner]` pulses, `last` <= owner, next state WAIT_DONE.
- Otherwise the counter increments. When the counter equals ACK_TIMEOUT-1 (abort):
  - `o_Tx_DV`, `o_enable`, `o_select`, `o_busy` <= 0
  - `o_err` pulses, `last` <= owner (the failed requester loses its turn)
  - no grant is issued; next state IDLE
- Ack and timeout in the same cycle: ack wins.
- `i_data_sent` is ignored in this state.
- Dropping `i_req[owner]` is ignored: the latched byte is still sent and granted.

**WAIT_DONE**
- `o_enable`/`o_select` stay at 1.
- On `i_data_sent`=1: `o_done[owner]` pulses; `o_enable`, `o_select`, `o_busy` <= 0; next state IDLE.
- No timeout in this state.

**Invariants**
- `o_grant`, `o_done` and `o_err` are mutually exclusive and one-hot or zero.
- At most one frame is in flight at any time.

**Reset**
- State IDLE; `last` = N-1; counter 0.
- All outputs 0, including `o_owner` = 0 and `o_Tx_b` = 0.
- Reset mid-frame drops `o_enable`/`o_select` on the next edge, so the UART abandons the frame. No `o_done` or `o_err` is issued.

## Timing
- Request to `o_Tx_DV`: 1 cycle (arbitrating edge).
- Against the UART: `o_Tx_DV` visible at t+1; the UART samples it and `i_data_recieved` is visible at t+2; `o_grant` and DV low at t+3. DV is therefore high for exactly 2 cycles in the normal case.
- `i_data_sent` to `o_done`: 1 cycle.
- Back-to-back frames: the next arbitration happens on the first IDLE cycle with `i_ready`=1. This is the cycle after the UART's CLEANUP, with no added gap.
- The timeout counter is m-independent and wide enough for ACK_TIMEOUT-1.

## Test plan
- **Reset:** assert `i_rst` 2 cycles with `i_req`=4'b1111 -> all outputs 0, no DV, `o_owner`=0.
- **Single request:** `i_req`=0010, byte1=8'hA5, `i_ready`=1, UART model attached -> DV high 2 cycles with `o_Tx_b`=A5 and `o_owner`=1; then `o_grant`=0010; serial line shows 0xA5 LSB-first; then `o_done`=0010; `o_busy` low after.
- **Fairness:** `i_req`=1111 held continuously -> grant order 0,1,2,3,0,1. Each `o_done` precedes the next DV.
- **Wrap and skip:** `i_req`=0101 -> requester 0 then 2. With `last`=2, requests 1010 -> 3 is served before 1.
- **Ack timeout:** `i_data_recieved` tied 0 with `i_req`=0011 -> DV high 16 cycles, `o_err` pulse, no grant, enable low. Next arbitration picks requester 1.
- **Reset mid-frame:** pulse `i_rst` during WAIT_DONE -> next edge all outputs 0 and state IDLE, no `o_done`. After `i_ready` returns, the still-pending request is served starting from requester 0.
